peripheral_dbg_pu_riscv_toggle_tx: RTL

Source-side transmitter of the debug unit's toggle-handshake clock-domain crossing. Accepts data words with a valid/ready handshake, holds each word stable on a parallel bus and signals it with a single level flip on a toggle wire. It then waits for the destination's returned acknowledge toggle before accepting the next word. It pairs with the destination-side toggle synchroniser/detector and sits in the debug module wherever commands or status cross from the JTAG/TAP clock into the CPU or bus clock, and vice versa.

---
 rtl/peripheral_dbg_pu_riscv_toggle_pkg.sv | 11 +
 rtl/peripheral_dbg_pu_riscv_toggle_tx_if.sv | 25 ++
 rtl/peripheral_dbg_pu_riscv_toggle_det.sv | 23 ++
 rtl/peripheral_dbg_pu_riscv_toggle_tx.sv | 97 +++++++++
 4 files changed

// File: rtl/peripheral_dbg_pu_riscv_toggle_pkg.sv
// Shared types and defaults for the debug-unit toggle-handshake CDC.
package peripheral_dbg_pu_riscv_toggle_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/peripheral_dbg_pu_riscv_toggle_tx_if.sv
// Source-side handshake bundle of the toggle transmitter.
interface peripheral_dbg_pu_riscv_toggle_tx_if #(
  parameter int unsigned DW = 32
);
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] IN_DATA;
  logic [DW-1:0] DATA_OUT;
  logic          TOGGLE_OUT;
  logic          ACK_TOGGLE_IN;
  logic          BUSY;
  logic          STALL;
  logic          PROTO_ERR;
  logic          CLR_FLAGS;

  modport slave (
    input  IN_VALID, IN_DATA, ACK_TOGGLE_IN, CLR_FLAGS,
    output IN_READY, DATA_OUT, TOGGLE_OUT, BUSY, STALL, PROTO_ERR
  );

  modport master (
    output IN_VALID, IN_DATA, ACK_TOGGLE_IN, CLR_FLAGS,
    input  IN_READY, DATA_OUT, TOGGLE_OUT, BUSY, STALL, PROTO_ERR
  );
endinterface

// File: rtl/peripheral_dbg_pu_riscv_toggle_det.sv
// Two-flop synchroniser plus edge detector: one DET pulse per TOGGLE_IN level change.
module peripheral_dbg_pu_riscv_toggle_det (
  input  logic CLK,
  input  logic RESET,
  input  logic TOGGLE_IN,
  output logic DET
);
  logic s1_q, s2_q, prev_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= TOGGLE_IN;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign DET = s2_q ^ prev_q;
endmodule

// File: rtl/peripheral_dbg_pu_riscv_toggle_tx.sv
// Toggle-handshake transmitter: holds a word on DATA_OUT, flips TOGGLE_OUT,
// then waits for the returned ack toggle before accepting the next word.
module peripheral_dbg_pu_riscv_toggle_tx
  import peripheral_dbg_pu_riscv_toggle_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic                                 CLK,
  input logic                                 RESET,
  peripheral_dbg_pu_riscv_toggle_tx_if.slave  bus
);
  localparam int unsigned     CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   TMAX = CW'(TIMEOUT);

  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          tog_q, tog_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_q, stall_d;
  logic          perr_q, perr_d;
  logic          ack_det;
  logic          accept;
  logic          stall_set;
  logic          perr_set;

  peripheral_dbg_pu_riscv_toggle_det u_ack_det (
    .CLK       (CLK),
    .RESET     (RESET),
    .TOGGLE_IN (bus.ACK_TOGGLE_IN),
    .DET       (ack_det)
  );

  assign accept    = (state_q == IDLE) && bus.IN_VALID;
  assign perr_set  = (state_q == IDLE) && ack_det;
  // Flag only on the transition into saturation so a clear while still waiting sticks.
  assign stall_set = (TIMEOUT != 0) && (state_q == WAIT_ACK) &&
                     (cnt_q != TMAX) && (cnt_d == TMAX);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tog_d   = tog_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.IN_VALID) begin
          data_d  = bus.IN_DATA;
          tog_d   = ~tog_q;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (cnt_q != TMAX) cnt_d = cnt_q + 1'b1;
        if (ack_det) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    perr_d  = perr_q;
    if (bus.CLR_FLAGS) begin
      stall_d = 1'b0;
      perr_d  = 1'b0;
    end
    if (stall_set) stall_d = 1'b1;
    if (perr_set)  perr_d  = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      data_q  <= '0;
      tog_q   <= 1'b0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tog_q   <= tog_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.IN_READY   = (state_q == IDLE);
  assign bus.BUSY       = (state_q == WAIT_ACK);
  assign bus.DATA_OUT   = data_q;
  assign bus.TOGGLE_OUT = tog_q;
  assign bus.STALL      = stall_q;
  assign bus.PROTO_ERR  = perr_q;
endmodule
